// File: rtl/wasca_buttons.sv
// wasca_buttons: debounced button/switch input port with edge capture
// and a level interrupt, exposed as a 4-register Avalon-MM slave.
module wasca_buttons #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [15:0] CntMax = 16'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]       sync1_q, sync1_d;
  logic [WIDTH-1:0]       sync2_q, sync2_d;
  logic [WIDTH-1:0]       stab_q, stab_d;
  logic [WIDTH-1:0]       prev_q, prev_d;
  logic [WIDTH-1:0][15:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]       irqmask_q, irqmask_d;
  logic [WIDTH-1:0]       edgecap_q, edgecap_d;
  logic [31:0]            readdata_q, readdata_d;

  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] clr;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  // Synchronize inputs and debounce each bit against its stable value.
  always_comb begin
    sync1_d = in_port;
    sync2_d = sync1_q;
    stab_d  = stab_q;
    prev_d  = stab_q;
    cnt_d   = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (sync2_q[i] != stab_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stab_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 16'd1;
        end
      end
    end
  end

  // Select which stable-value transitions count as edges.
  always_comb begin
    edge_hit = '0;
    if (EDGE_TYPE == 0) begin
      edge_hit = stab_q & ~prev_q;
    end else if (EDGE_TYPE == 1) begin
      edge_hit = ~stab_q & prev_q;
    end else begin
      edge_hit = stab_q ^ prev_q;
    end
  end

  // Register writes; a new edge beats a same-cycle clear.
  always_comb begin
    clr       = '0;
    irqmask_d = irqmask_q;
    if (wr_en && address == 2'd3) begin
      clr = wdata;
    end
    if (wr_en && address == 2'd2) begin
      irqmask_d = wdata;
    end
    edgecap_d = (edgecap_q & ~clr) | edge_hit;
  end

  // Read mux, loaded every cycle regardless of chipselect.
  always_comb begin
    readdata_d = '0;
    unique case (address)
      2'd0:    readdata_d = 32'(stab_q);
      2'd1:    readdata_d = '0;
      2'd2:    readdata_d = 32'(irqmask_q);
      default: readdata_d = 32'(edgecap_q);
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stab_q     <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      stab_q     <= stab_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_wasca_buttons.sv
// tb_wasca_buttons: scoreboard bench for wasca_buttons, three
// instances (rising, falling, any edge) sharing one stimulus stream.
module tb_wasca_buttons;

  localparam int W = 4;
  localparam int D = 4;

  typedef logic [2:0][31:0] exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [W-1:0]  in_port = '0;
  logic [2:0][31:0] rdata;
  logic [2:0]    irq_v;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [W-1:0]      hin[$];
  logic [W-1:0]      shist[$];
  logic [W-1:0]      stab_m = '0;
  logic [W-1:0]      prev_m = '0;
  logic [W-1:0]      mask_m = '0;
  logic [2:0][W-1:0] ecap_m = '0;
  exp_t              eq[$];

  always #5 clk = ~clk;

  wasca_buttons #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)) u0 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rdata[0]),
    .in_port(in_port), .irq(irq_v[0]));

  wasca_buttons #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1)) u1 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rdata[1]),
    .in_port(in_port), .irq(irq_v[1]));

  wasca_buttons #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2)) u2 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rdata[2]),
    .in_port(in_port), .irq(irq_v[2]));

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t",
               nm, act, exp, $time);
    end
  endfunction

  function automatic logic [W-1:0] edges(int et, logic [W-1:0] s,
                                         logic [W-1:0] p);
    if (et == 0) return s & ~p;
    if (et == 1) return ~s & p;
    return s ^ p;
  endfunction

  function automatic logic [31:0] rdm(int k);
    case (address)
      2'd0:    return 32'(stab_m);
      2'd1:    return 32'd0;
      2'd2:    return 32'(mask_m);
      default: return 32'(ecap_m[k]);
    endcase
  endfunction

  // Model: a bit is accepted once the last D synchronized samples
  // all disagree with its stable value.
  always @(posedge clk) begin
    logic [W-1:0] sc;
    logic [W-1:0] clr;
    logic         all;
    exp_t         x;
    if (!reset_n) begin
      hin.delete();
      hin.push_back('0);
      hin.push_back('0);
      shist.delete();
      stab_m = '0;
      prev_m = '0;
      mask_m = '0;
      ecap_m = '0;
    end else begin
      if (chipselect && write_n) begin
        for (int k = 0; k < 3; k++) x[k] = rdm(k);
        eq.push_back(x);
      end
      clr = '0;
      if (chipselect && !write_n && address == 2'd3)
        clr = writedata[W-1:0];
      for (int k = 0; k < 3; k++)
        ecap_m[k] = (ecap_m[k] & ~clr) | edges(k, stab_m, prev_m);
      if (chipselect && !write_n && address == 2'd2)
        mask_m = writedata[W-1:0];
      prev_m = stab_m;
      sc = hin[0];
      shist.push_back(sc);
      if (shist.size() > D) void'(shist.pop_front());
      if (shist.size() == D) begin
        for (int i = 0; i < W; i++) begin
          all = 1'b1;
          foreach (shist[j]) if (shist[j][i] == stab_m[i]) all = 1'b0;
          if (all) stab_m[i] = ~stab_m[i];
        end
      end
      void'(hin.pop_front());
      hin.push_back(in_port);
    end
  end

  // Monitor: irq every cycle, readdata whenever a read was issued.
  always @(negedge clk) begin
    exp_t x;
    if (!reset_n) begin
      eq.delete();
    end else begin
      for (int k = 0; k < 3; k++)
        chk($sformatf("irq%0d", k), 32'(irq_v[k]),
            32'(|(ecap_m[k] & mask_m)));
      while (eq.size() > 0) begin
        x = eq.pop_front();
        for (int k = 0; k < 3; k++)
          chk($sformatf("rd%0d", k), rdata[k], x[k]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      chipselect = 1'b1;
      write_n    = 1'b1;
      address    = 2'($urandom_range(0, 3));
      tick();
    end
    chipselect = 1'b0;
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = $urandom;
  endtask

  task automatic rd(logic [1:0] a);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    tick();
    chipselect = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int hold;
    int r;
    hold = 0;
    reset_n = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      chk("rst_rd", rdata[k], 32'd0);
      chk("rst_irq", 32'(irq_v[k]), 32'd0);
    end
    reset_n = 1'b1;
    idle(3);

    in_port = 4'h1;
    repeat (6) rd(2'd0);
    chk("lat_pre", rdata[0], 32'd0);
    rd(2'd0);
    chk("lat_post", rdata[0], 32'd1);
    rd(2'd3);
    chk("ecap_rise", rdata[0], 32'd1);
    chk("irq_nomask", 32'(irq_v[0]), 32'd0);
    wr(2'd2, 32'h1);
    chk("irq_mask", 32'(irq_v[0]), 32'd1);
    wr(2'd3, 32'h1);
    chk("irq_clr", 32'(irq_v[0]), 32'd0);

    repeat (2) begin
      in_port = 4'h3;
      repeat (3) tick();
      in_port = 4'h1;
      tick();
    end
    idle(10);
    rd(2'd0);
    chk("glitch_data", rdata[0], 32'd1);
    rd(2'd3);
    chk("glitch_ecap", rdata[0], 32'd0);

    in_port = 4'h0;
    idle(10);
    wr(2'd3, 32'hF);
    in_port = 4'h1;
    repeat (6) tick();
    wr(2'd3, 32'h1);
    chk("set_wins_irq", 32'(irq_v[0]), 32'd1);
    rd(2'd3);
    chk("set_wins", rdata[0], 32'd1);

    wr(2'd3, 32'hF);
    in_port = 4'h5;
    idle(10);
    rd(2'd3);
    chk("any_rise", 32'(rdata[2][2]), 32'd1);
    wr(2'd3, 32'hF);
    in_port = 4'h1;
    idle(10);
    rd(2'd3);
    chk("any_fall", 32'(rdata[2][2]), 32'd1);
    chk("rise_no_fall", 32'(rdata[0][2]), 32'd0);

    in_port = 4'h0;
    idle(10);
    in_port = 4'hF;
    idle(10);
    rd(2'd3);
    chk("ecap_all", rdata[0], 32'hF);
    in_port = 4'h0;
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("mid_rst_rd", rdata[k], 32'd0);
      chk("mid_rst_irq", 32'(irq_v[k]), 32'd0);
    end
    repeat (2) tick();
    reset_n = 1'b1;
    rd(2'd1);
    chk("rst_a1", rdata[0], 32'd0);
    rd(2'd3);
    chk("rst_ecap", rdata[0], 32'd0);
    rd(2'd2);
    chk("rst_mask", rdata[0], 32'd0);
    rd(2'd0);
    chk("rst_data", rdata[0], 32'd0);

    in_port = 4'hF;
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    idle(12);
    rd(2'd3);
    chk("held_rst_ecap", rdata[0], 32'hF);

    for (int c = 0; c < 2000; c++) begin
      if (hold == 0) begin
        in_port = W'($urandom);
        hold = $urandom_range(1, 10);
      end else begin
        hold--;
      end
      r = $urandom_range(0, 9);
      address = 2'($urandom_range(0, 3));
      if (r < 2) begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = $urandom;
      end else if (r < 8) begin
        chipselect = 1'b1;
        write_n    = 1'b1;
      end else begin
        chipselect = 1'b0;
        write_n    = 1'($urandom_range(0, 1));
      end
      tick();
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wasca_buttons.md
WASCA_BUTTONS -- requirements
Module: wasca_buttons

Interface
REQ-001 The parameter list SHALL be, one per line: name, default, meaning.
- WIDTH, 4, number of input bits (1..32).
- DEBOUNCE_CYCLES, 16, consecutive cycles a changed input must hold before acceptance (1..65535).
- EDGE_TYPE, 0, capture edge: 0 rising, 1 falling, 2 any.

REQ-002 The port list SHALL be, one per line: name, direction, width, meaning.
- clk, input, 1, sole clock; all state on rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- address, input, 2, Avalon-MM slave register select.
- chipselect, input, 1, slave select.
- write_n, input, 1, active-low write strobe.
- writedata, input, 32, write data.
- readdata, output, 32, registered read data.
- in_port, input, WIDTH, asynchronous external inputs (buttons/switches).
- irq, output, 1, active-high level interrupt.

REQ-003 One clock; reset is asynchronous and active-low (clk, reset_n).

Function
REQ-004 Each in_port bit SHALL pass a 2-flop synchronizer; the synchronized value is sync[i].
REQ-005 Each bit SHALL have a stable register stab[i] and a 16-bit counter cnt[i].
REQ-006 Debounce, per bit and per cycle:
- sync[i]==stab[i]: cnt[i] <= 0.
- Otherwise, while cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] increments.
- When cnt[i]==DEBOUNCE_CYCLES-1: stab[i] <= sync[i] and cnt[i] <= 0.
REQ-007 Any glitch shorter than DEBOUNCE_CYCLES cycles (measured at sync) SHALL leave stab unchanged and SHALL restart the count.
REQ-008 Latency from an in_port change to stab: 2 synchronizer cycles + DEBOUNCE_CYCLES cycles.
REQ-009 Edge detection SHALL compare stab with its previous-cycle value:
- EDGE_TYPE 0: 0->1 is an edge.
- EDGE_TYPE 1: 1->0 is an edge.
- EDGE_TYPE 2: either transition is an edge.
REQ-010 A detected edge SHALL set edgecap[i] on the following clock.
REQ-011 Register map (32-bit; bits >= WIDTH read 0, writes to them ignored):
- 0 DATA: stab, RO, writes ignored.
- 1: reads 0, writes ignored.
- 2 IRQMASK: RW, reset 0.
- 3 EDGECAP: read returns edgecap; write-1-to-clear per bit.
REQ-012 A write SHALL occur only when chipselect=1 and write_n=0 on a clock edge.
REQ-013 Simultaneous clear-write and new edge on the same bit: set SHALL win, and the bit reads 1 afterwards.
REQ-014 readdata SHALL be registered: each clock it loads the address mux output regardless of chipselect, giving a read latency of 1 cycle.
REQ-015 irq SHALL equal OR over i of (edgecap[i] AND irqmask[i]), driven combinationally from registers with no extra delay.
REQ-016 Writing IRQMASK with a pending edgecap bit SHALL assert irq in the cycle after the write; clearing the mask SHALL deassert irq likewise.

Reset
REQ-017 While reset_n=0 the following SHALL be 0: synchronizer flops, stab, previous stab, cnt, irqmask, edgecap, readdata, irq.
REQ-018 Reset assertion mid-debounce or with edges pending SHALL discard all progress and pending state immediately.
REQ-019 An input held at 1 through reset SHALL be treated as a 0->1 transition after release: stab rises after 2+DEBOUNCE_CYCLES cycles, and EDGE_TYPE 0 captures it.

Verification
REQ-020 A bench SHALL cover these directed scenarios (DEBOUNCE_CYCLES=4, WIDTH=4, EDGE_TYPE=0 unless stated):
- in_port 0000->0001 held -> DATA reads 0x1 with stab rising 6 cycles after the change; EDGECAP=0x1; irq=0 with mask 0.
- Write IRQMASK=0x1 -> irq=1 next cycle; write EDGECAP=0x1 -> edgecap=0 and irq=0 next cycle.
- in_port bit1 pulsed high for 3 cycles, repeated twice with 1-cycle gaps -> stab bit1 never changes; EDGECAP stays 0.
- Clear-write of bit0 in the same cycle as a new bit0 edge -> EDGECAP reads 0x1; irq stays 1 if masked.
- EDGE_TYPE=2, bit2 goes 0->1, clear, then 1->0 -> EDGECAP bit2 is set on each transition.
- reset_n pulsed low mid-debounce with EDGECAP=0xF -> all registers, readdata and irq are 0; address 1 reads 0x0.
